seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 21 ++
 rtl/bcd_seven.sv | 26 ++
 rtl/seg_scan_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and segment constants for the multiplexed seven-segment scanner.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_GAP   = 2'd2
    } scan_state_t;

    localparam int unsigned SEG_W    = 7;
    localparam int unsigned NIBBLE_W = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b0111111;

    // Width of a counter or index that must hold values 0..limit-1 (never zero bits).
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/bcd_seven.sv
// Combinational BCD to seven-segment decoder; seg bit order is g..a, nibbles above 9 go dark.
module bcd_seven
    import seg_pkg::*;
(
    input  logic [NIBBLE_W-1:0] bcd,
    output logic [SEG_W-1:0]    seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a tear-free double-buffered display value.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading-zero digits (digit 0 always shown).
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned N_DIGITS  = 4,
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load_valid,
    input  logic [4*N_DIGITS-1:0]   load_bcd,
    output logic                    load_ready,
    output logic [7:1]              seg,
    output logic [N_DIGITS-1:0]     an
);

    localparam int unsigned IDX_W   = cnt_width(N_DIGITS);
    localparam int unsigned DW_W    = cnt_width(TICK_DIV);
    localparam int unsigned GAP_W   = cnt_width(BLANK_CYC);
    localparam int unsigned VALUE_W = NIBBLE_W * N_DIGITS;

    scan_state_t        state, state_d;
    logic [DW_W-1:0]    dwell_cnt, dwell_cnt_d;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
    logic [IDX_W-1:0]   idx, idx_d;

    logic [VALUE_W-1:0] display, display_d;
    logic [VALUE_W-1:0] pending, pending_d;
    logic               pending_full, pending_full_d;

    logic               dwell_done_c;
    logic               gap_done_c;
    logic               last_digit_c;
    logic               wrap_c;
    logic               to_idle_c;
    logic               accept_c;
    logic               lit_c;
    logic               blank_c;
    logic [NIBBLE_W-1:0] nibble_c;
    logic [SEG_W-1:0]   dec_seg_c;
    logic [SEG_W-1:0]   seg_c;
    logic [N_DIGITS-1:0] an_c;

    assign dwell_done_c = (dwell_cnt == DW_W'(TICK_DIV - 1));
    assign gap_done_c   = (gap_cnt == GAP_W'(BLANK_CYC - 1));
    assign last_digit_c = (idx == IDX_W'(N_DIGITS - 1));
    assign wrap_c       = (state == ST_GAP) && enable && gap_done_c && last_digit_c;
    assign to_idle_c    = (state != ST_IDLE) && !enable;
    assign accept_c     = load_valid && load_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state, dwell/gap counters and digit index
    always_comb begin
        state_d     = state;
        dwell_cnt_d = '0;
        gap_cnt_d   = '0;
        idx_d       = idx;
        case (state)
            ST_IDLE: begin
                idx_d = '0;
                if (enable) begin
                    state_d = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (dwell_done_c) begin
                    state_d = ST_GAP;
                end else begin
                    dwell_cnt_d = dwell_cnt + DW_W'(1);
                end
            end
            ST_GAP: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (gap_done_c) begin
                    state_d = ST_DWELL;
                    idx_d   = last_digit_c ? '0 : idx + IDX_W'(1);
                end else begin
                    gap_cnt_d = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Display buffering: pending only moves to display at a frame wrap or on leaving the scan
    always_comb begin
        display_d      = display;
        pending_d      = pending;
        pending_full_d = pending_full;
        if (state == ST_IDLE) begin
            if (accept_c) begin
                display_d = load_bcd;
            end
        end else if (to_idle_c) begin
            if (accept_c) begin
                display_d = load_bcd;
            end else if (pending_full) begin
                display_d = pending;
            end
            pending_full_d = 1'b0;
        end else if (accept_c) begin
            pending_d      = load_bcd;
            pending_full_d = 1'b1;
        end else if (wrap_c && pending_full) begin
            display_d      = pending;
            pending_full_d = 1'b0;
        end
    end

    assign nibble_c = display[{idx, 2'b00} +: NIBBLE_W];

    bcd_seven u_bcd_seven (
        .bcd (nibble_c),
        .seg (dec_seg_c)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msnz_c;

    // Index of the most significant nonzero nibble; 0 when the whole value is zero
    always_comb begin
        msnz_c = '0;
        for (int k = 0; k < int'(N_DIGITS); k++) begin
            if (display[NIBBLE_W*k +: NIBBLE_W] != '0) begin
                msnz_c = IDX_W'(k);
            end
        end
    end

    assign blank_c = (idx > msnz_c);
`else
    assign blank_c = 1'b0;
`endif

    assign lit_c = (state == ST_DWELL) && enable;
    assign an_c  = lit_c ? (N_DIGITS'(1) << idx) : '0;
    assign seg_c = (lit_c && !blank_c) ? dec_seg_c : SEG_BLANK;

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt    <= '0;
            gap_cnt      <= '0;
            idx          <= '0;
            display      <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            load_ready   <= 1'b0;
            seg          <= SEG_BLANK;
            an           <= '0;
        end else begin
            dwell_cnt    <= dwell_cnt_d;
            gap_cnt      <= gap_cnt_d;
            idx          <= idx_d;
            display      <= display_d;
            pending      <= pending_d;
            pending_full <= pending_full_d;
            load_ready   <= !pending_full_d;
            seg          <= seg_c;
            an           <= an_c;
        end
    end

endmodule
